// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types, opcode constants and access-size helpers for the
// memory-access stage of the five-stage MIPS pipeline.
package mem_bus_ctrl_pkg;

  // Datapath widths (AluOpBus / RegBus in the legacy defines)
  localparam int ALU_OP_W = 8;
  localparam int REG_W    = 32;

  typedef logic [ALU_OP_W-1:0] alu_op_t;
  typedef logic [REG_W-1:0]    reg_t;

  // MemStateBus and its encodings
  typedef logic [1:0] mem_state_t;
  localparam mem_state_t ST_IDLE = 2'd0;
  localparam mem_state_t ST_BUSY = 2'd1;
  localparam mem_state_t ST_DONE = 2'd2;

  // Load/store opcodes issued by the execute stage
  localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

  // Width of a memory access; ACC_NONE marks a non-memory opcode
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_BYTE = 2'd1,
    ACC_HALF = 2'd2,
    ACC_WORD = 2'd3
  } acc_size_e;

  function automatic acc_size_e op_size(input alu_op_t op);
    acc_size_e sz;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sz = ACC_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sz = ACC_HALF;
      EXE_LW_OP, EXE_SW_OP:             sz = ACC_WORD;
      default:                          sz = ACC_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_load(input alu_op_t op);
    return (op == EXE_LB_OP)  || (op == EXE_LBU_OP) ||
           (op == EXE_LH_OP)  || (op == EXE_LHU_OP) ||
           (op == EXE_LW_OP);
  endfunction

  // Only LB and LH sign-extend; LBU/LHU zero-extend
  function automatic logic op_is_signed(input alu_op_t op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_align.sv
// mem_align: purely combinational lane logic for the memory stage.
// Request side builds byte enables, replicated store data and the
// misalignment flag; response side extracts and extends load data.
// Byte order is big-endian: addr[1:0] == 0 selects lane [31:24].
module mem_align
  import mem_bus_ctrl_pkg::*;
(
  input  alu_op_t    req_op_i,
  input  logic [1:0] req_addr_lo_i,
  input  reg_t       store_data_i,
  output logic       is_mem_o,
  output logic       is_load_o,
  output logic       misaligned_o,
  output logic [3:0] sel_o,
  output reg_t       wdata_o,
  input  alu_op_t    rsp_op_i,
  input  logic [1:0] rsp_addr_lo_i,
  input  reg_t       load_data_i,
  output reg_t       load_result_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  // Request side: lane enables, store replication and alignment check
  always_comb begin
    is_mem_o     = 1'b0;
    is_load_o    = op_is_load(req_op_i);
    misaligned_o = 1'b0;
    sel_o        = 4'b0000;
    wdata_o      = store_data_i;
    case (op_size(req_op_i))
      ACC_BYTE: begin
        is_mem_o = 1'b1;
        sel_o    = 4'b1000 >> req_addr_lo_i;
        wdata_o  = {4{store_data_i[7:0]}};
      end
      ACC_HALF: begin
        is_mem_o     = 1'b1;
        sel_o        = req_addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o      = {2{store_data_i[15:0]}};
        misaligned_o = req_addr_lo_i[0];
      end
      ACC_WORD: begin
        is_mem_o     = 1'b1;
        sel_o        = 4'b1111;
        wdata_o      = store_data_i;
        misaligned_o = |req_addr_lo_i;
      end
      default: begin
        is_mem_o = 1'b0;
      end
    endcase
  end

  // Response side: pick the addressed lane and extend it to 32 bits
  always_comb begin
    ld_signed = op_is_signed(rsp_op_i);
    case (rsp_addr_lo_i)
      2'd0:    ld_byte = load_data_i[31:24];
      2'd1:    ld_byte = load_data_i[23:16];
      2'd2:    ld_byte = load_data_i[15:8];
      default: ld_byte = load_data_i[7:0];
    endcase
    ld_half = rsp_addr_lo_i[1] ? load_data_i[15:0] : load_data_i[31:16];
    case (op_size(rsp_op_i))
      ACC_BYTE: load_result_o = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      ACC_HALF: load_result_o = {{16{ld_signed & ld_half[15]}}, ld_half};
      ACC_WORD: load_result_o = load_data_i;
      default:  load_result_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: memory-access stage. Runs one request/acknowledge bus
// transaction per aligned load/store, stalls the pipeline until it
// completes, and aborts a transaction that waits TIMEOUT cycles.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
)
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_OP_W-1:0] aluop_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         reg2_i,
  input  logic [4:0]          wd_i,
  input  logic                wreg_i,
  input  logic [31:0]         wdata_i,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [31:0]         wdata_o,
  output logic                stallreq_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [31:0]         bus_addr_o,
  output logic [3:0]          bus_sel_o,
  output logic [31:0]         bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [31:0]         bus_rdata_i,
  output logic                err_o
);

  // Counter value seen in the last permitted BUSY cycle
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  mem_state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       abort_q, abort_d;
  reg_t       addr_q, addr_d;
  logic [3:0] sel_q, sel_d;
  logic       we_q, we_d;
  reg_t       wdata_q, wdata_d;
  reg_t       rdata_q, rdata_d;
  alu_op_t    op_q, op_d;

  logic       is_mem;
  logic       is_load;
  logic       misaligned;
  logic [3:0] req_sel;
  reg_t       req_wdata;
  reg_t       load_result;

  mem_align u_align (
    .req_op_i      (aluop_i),
    .req_addr_lo_i (mem_addr_i[1:0]),
    .store_data_i  (reg2_i),
    .is_mem_o      (is_mem),
    .is_load_o     (is_load),
    .misaligned_o  (misaligned),
    .sel_o         (req_sel),
    .wdata_o       (req_wdata),
    .rsp_op_i      (op_q),
    .rsp_addr_lo_i (addr_q[1:0]),
    .load_data_i   (rdata_q),
    .load_result_o (load_result)
  );

  // Next-state logic: latch the request in IDLE, count and wait for ack in BUSY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (is_mem && !misaligned) begin
          addr_d  = mem_addr_i;
          sel_d   = req_sel;
          we_d    = ~is_load;
          wdata_d = req_wdata;
          op_d    = aluop_i;
          cnt_d   = 8'd0;
          abort_d = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus_ack_i) begin
          rdata_d = bus_rdata_i;
          cnt_d   = 8'd0;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          abort_d = 1'b1;
          cnt_d   = 8'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      op_q    <= op_d;
    end
  end

  // Output decode; everything is forced low while reset is held
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stallreq_o  = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_sel_o   = 4'b0000;
    bus_wdata_o = '0;
    err_o       = 1'b0;
    if (!rst) begin
      wd_o = wd_i;
      case (state_q)
        ST_IDLE: begin
          if (!is_mem) begin
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end else if (misaligned) begin
            err_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        ST_BUSY: begin
          stallreq_o  = 1'b1;
          bus_req_o   = 1'b1;
          bus_we_o    = we_q;
          bus_addr_o  = {addr_q[31:2], 2'b00};
          bus_sel_o   = sel_q;
          bus_wdata_o = wdata_q;
        end
        ST_DONE: begin
          if (abort_q) begin
            err_o = 1'b1;
          end else if (op_is_load(op_q)) begin
            wreg_o  = wreg_i;
            wdata_o = load_result;
          end
        end
        default: begin
          wd_o = wd_i;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: the driver pushes expected bus
// requests and write-back responses; monitors pop and compare them.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  localparam logic [7:0] OP_OR  = 8'b0010_0101;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, reg2, wdata_in, rdata;
  logic [4:0]  wd_in;
  logic        wreg_in, ack;

  logic [4:0]  wd_o;
  logic        wreg_o, stallreq_o, bus_req_o, bus_we_o, err_o;
  logic [31:0] wdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;

  logic [4:0]  wd_t;
  logic        wreg_t, stall_t, bus_req_t, bus_we_t, err_t;
  logic [31:0] wdata_t, bus_addr_t, bus_wdata_t;
  logic [3:0]  bus_sel_t;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2),
    .wd_i(wd_in), .wreg_i(wreg_in), .wdata_i(wdata_in),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(ack), .bus_rdata_i(rdata), .err_o(err_o)
  );

  mem_bus_ctrl #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2),
    .wd_i(wd_in), .wreg_i(wreg_in), .wdata_i(wdata_in),
    .wd_o(wd_t), .wreg_o(wreg_t), .wdata_o(wdata_t), .stallreq_o(stall_t),
    .bus_req_o(bus_req_t), .bus_we_o(bus_we_t), .bus_addr_o(bus_addr_t),
    .bus_sel_o(bus_sel_t), .bus_wdata_o(bus_wdata_t),
    .bus_ack_i(ack), .bus_rdata_i(rdata), .err_o(err_t)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        chk_wdata;
  } bus_exp_t;

  typedef struct {
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_data;
    logic        err;
    logic [4:0]  wd;
    int          stalls;
    int          reqs;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int       to_q[$];

  int          tests = 0;
  int          fails = 0;
  logic        op_valid = 1'b0;
  int          ack_at = 0;
  logic [31:0] rdata_cfg = '0;

  int          busy_idx = 0;
  int          stall_cnt = 0, req_cnt = 0;
  logic        req_prev = 1'b0, unstable = 1'b0;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_sel;
  int          run_t = 0, last_t = 0;
  bus_exp_t    bexp;
  rsp_exp_t    rexp;
  int          texp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectBus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wdata, input logic chk);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.sel = sel; e.wdata = wdata; e.chk_wdata = chk;
    bus_q.push_back(e);
  endtask

  task automatic expectRsp(input logic wreg, input logic [31:0] wdata, input logic chk,
                           input logic err, input logic [4:0] wd, input int stalls, input int reqs);
    rsp_exp_t e;
    e.wreg = wreg; e.wdata = wdata; e.chk_data = chk; e.err = err;
    e.wd = wd; e.stalls = stalls; e.reqs = reqs;
    rsp_q.push_back(e);
  endtask

  // Called at posedge+2; holds the op until the stage stops stalling
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                               input logic [31:0] wdin, input logic [4:0] wd, input logic wreg,
                               input int ackAt, input logic [31:0] rd);
    int n;
    aluop = op; mem_addr = addr; reg2 = data; wdata_in = wdin;
    wd_in = wd; wreg_in = wreg; ack_at = ackAt; rdata_cfg = rd;
    op_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stallreq_o && n < 60);
    if (stallreq_o) begin
      tests++; fails++;
      $display("[TB] FAIL stall_bound: stall still 1 after %0d cycles, expected 0", n);
    end
    @(posedge clk); #2;
    op_valid = 1'b0;
    aluop = OP_NOP; mem_addr = '0; reg2 = '0; wdata_in = '0; wd_in = '0; wreg_in = 1'b0;
  endtask

  // Bus slave: acks in the programmed BUSY cycle (1-based), 0 = never
  initial begin
    ack = 1'b0; rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (rst || !bus_req_o) begin
        busy_idx = 0; ack = 1'b0; rdata = '0;
      end else begin
        busy_idx++;
        if (busy_idx == ack_at) begin ack = 1'b1; rdata = rdata_cfg; end
        else begin ack = 1'b0; rdata = '0; end
      end
    end
  end

  // Main monitor: bus request fields, bus stability, write-back response
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_cnt = 0; req_cnt = 0; req_prev = 1'b0; unstable = 1'b0;
        continue;
      end
      if (bus_req_o) begin
        if (!req_prev) begin
          req_cnt = 1; unstable = 1'b0;
          snap_we = bus_we_o; snap_addr = bus_addr_o; snap_sel = bus_sel_o; snap_wdata = bus_wdata_o;
          if (bus_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL bus_unexpected: bus_req 1 with addr 0x%08h, expected no request", bus_addr_o);
          end else begin
            bexp = bus_q.pop_front();
            checkOutput("bus_we", 32'(bus_we_o), 32'(bexp.we));
            checkOutput("bus_addr", bus_addr_o, bexp.addr);
            checkOutput("bus_sel", 32'(bus_sel_o), 32'(bexp.sel));
            if (bexp.chk_wdata) checkOutput("bus_wdata", bus_wdata_o, bexp.wdata);
          end
        end else begin
          req_cnt++;
          if (bus_we_o !== snap_we || bus_addr_o !== snap_addr ||
              bus_sel_o !== snap_sel || bus_wdata_o !== snap_wdata) unstable = 1'b1;
        end
      end
      req_prev = bus_req_o;
      if (op_valid) begin
        if (stallreq_o) begin
          stall_cnt++;
        end else begin
          if (rsp_q.size() == 0) begin
            tests++; fails++;
            $display("[TB] FAIL rsp_unexpected: response with wreg %0b err %0b, expected none", wreg_o, err_o);
          end else begin
            rexp = rsp_q.pop_front();
            checkOutput("wreg", 32'(wreg_o), 32'(rexp.wreg));
            checkOutput("err", 32'(err_o), 32'(rexp.err));
            checkOutput("wd", 32'(wd_o), 32'(rexp.wd));
            if (rexp.chk_data) checkOutput("wdata", wdata_o, rexp.wdata);
            checkOutput("stall_cycles", 32'(stall_cnt), 32'(rexp.stalls));
            checkOutput("req_cycles", 32'(req_cnt), 32'(rexp.reqs));
            checkOutput("bus_unstable", 32'(unstable), 32'd0);
          end
          stall_cnt = 0; req_cnt = 0; unstable = 1'b0;
        end
      end
    end
  end

  // Monitor for the TIMEOUT=4 instance: request burst length at abort
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin run_t = 0; last_t = 0; continue; end
      if (bus_req_t) run_t++;
      else if (run_t != 0) begin last_t = run_t; run_t = 0; end
      if (err_t && to_q.size() != 0) begin
        texp = to_q.pop_front();
        checkOutput("to_req_cycles", 32'(last_t), 32'(texp));
        checkOutput("to_wreg", 32'(wreg_t), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    aluop = OP_OR; mem_addr = 32'h0000_0104; reg2 = 32'h1234_5678;
    wdata_in = 32'h55; wd_in = 5'd7; wreg_in = 1'b1;
    #12;
    checkOutput("rst_bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("rst_bus_we", 32'(bus_we_o), 32'd0);
    checkOutput("rst_bus_addr", bus_addr_o, 32'd0);
    checkOutput("rst_bus_sel", 32'(bus_sel_o), 32'd0);
    checkOutput("rst_bus_wdata", bus_wdata_o, 32'd0);
    checkOutput("rst_stall", 32'(stallreq_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_wreg", 32'(wreg_o), 32'd0);
    checkOutput("rst_wdata", wdata_o, 32'd0);
    checkOutput("rst_wd", 32'(wd_o), 32'd0);
    aluop = OP_NOP; mem_addr = '0; reg2 = '0; wdata_in = '0; wd_in = '0; wreg_in = 1'b0;
    #4 rst = 1'b0;
    @(posedge clk); #2;

    // SW aligned, immediate ack
    expectBus(1'b1, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 1'b1);
    expectRsp(1'b0, 32'h0, 1'b0, 1'b0, 5'd1, 2, 1);
    applyStimulus(EXE_SW_OP, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 5'd1, 1'b1, 1, 32'h0);
    // LB sign extension
    expectBus(1'b0, 32'h0000_0100, 4'b0010, 32'h0, 1'b0);
    expectRsp(1'b1, 32'hFFFF_FF83, 1'b1, 1'b0, 5'd2, 2, 1);
    applyStimulus(EXE_LB_OP, 32'h0000_0102, 32'h0, 32'h0, 5'd2, 1'b1, 1, 32'h1122_8344);
    // LHU low half
    expectBus(1'b0, 32'h0000_0104, 4'b0011, 32'h0, 1'b0);
    expectRsp(1'b1, 32'h0000_F00D, 1'b1, 1'b0, 5'd3, 2, 1);
    applyStimulus(EXE_LHU_OP, 32'h0000_0106, 32'h0, 32'h0, 5'd3, 1'b1, 1, 32'hBEEF_F00D);
    // LW with ack in the fifth BUSY cycle
    expectBus(1'b0, 32'h0000_0200, 4'b1111, 32'h0, 1'b0);
    expectRsp(1'b1, 32'h1234_5678, 1'b1, 1'b0, 5'd4, 6, 5);
    applyStimulus(EXE_LW_OP, 32'h0000_0200, 32'h0, 32'h0, 5'd4, 1'b1, 5, 32'h1234_5678);
    // SH misaligned: no bus cycle, error pulse
    expectRsp(1'b0, 32'h0, 1'b0, 1'b1, 5'd5, 0, 0);
    applyStimulus(EXE_SH_OP, 32'h0000_0101, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1, 32'h0);
    // SB to lowest lane, replicated data
    expectBus(1'b1, 32'h0000_0100, 4'b0001, 32'hABAB_ABAB, 1'b1);
    expectRsp(1'b0, 32'h0, 1'b0, 1'b0, 5'd6, 3, 2);
    applyStimulus(EXE_SB_OP, 32'h0000_0103, 32'h0000_00AB, 32'h0, 5'd6, 1'b0, 2, 32'h0);
    // SH low half, replicated data
    expectBus(1'b1, 32'h0000_0104, 4'b0011, 32'hCAFE_CAFE, 1'b1);
    expectRsp(1'b0, 32'h0, 1'b0, 1'b0, 5'd7, 2, 1);
    applyStimulus(EXE_SH_OP, 32'h0000_0106, 32'h1234_CAFE, 32'h0, 5'd7, 1'b1, 1, 32'h0);
    // LH high half, sign extension
    expectBus(1'b0, 32'h0000_0104, 4'b1100, 32'h0, 1'b0);
    expectRsp(1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 5'd8, 2, 1);
    applyStimulus(EXE_LH_OP, 32'h0000_0104, 32'h0, 32'h0, 5'd8, 1'b1, 1, 32'h8001_7FFF);
    // LBU top lane, zero extension
    expectBus(1'b0, 32'h0000_0100, 4'b1000, 32'h0, 1'b0);
    expectRsp(1'b1, 32'h0000_00F0, 1'b1, 1'b0, 5'd9, 4, 3);
    applyStimulus(EXE_LBU_OP, 32'h0000_0100, 32'h0, 32'h0, 5'd9, 1'b1, 3, 32'hF000_0000);
    // LW misaligned
    expectRsp(1'b0, 32'h0, 1'b0, 1'b1, 5'd10, 0, 0);
    applyStimulus(EXE_LW_OP, 32'h0000_0202, 32'h0, 32'h0, 5'd10, 1'b1, 1, 32'h0);
    // Ack in the very cycle the counter hits TIMEOUT=16 is a success
    expectBus(1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1'b0);
    expectRsp(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 5'd11, 17, 16);
    applyStimulus(EXE_LW_OP, 32'h0000_0010, 32'h0, 32'h0, 5'd11, 1'b1, 16, 32'hCAFE_F00D);

    // Resynchronise both instances before the timeout case
    rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #2;

    // Timeout: main instance after 16 BUSY cycles, small instance after 4
    expectBus(1'b0, 32'h0000_0300, 4'b1111, 32'h0, 1'b0);
    expectRsp(1'b0, 32'h0, 1'b0, 1'b1, 5'd12, 17, 16);
    to_q.push_back(4);
    applyStimulus(EXE_LW_OP, 32'h0000_0300, 32'h0, 32'h0, 5'd12, 1'b1, 0, 32'h0);

    // Reset in the middle of a BUSY phase
    rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #2;
    expectBus(1'b0, 32'h0000_0400, 4'b1111, 32'h0, 1'b0);
    aluop = EXE_LW_OP; mem_addr = 32'h0000_0400; wd_in = 5'd13; wreg_in = 1'b1; ack_at = 0;
    op_valid = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_bus_req", 32'(bus_req_o), 32'd1);
    #1;
    rst = 1'b1; op_valid = 1'b0;
    #1;
    checkOutput("midrst_bus_req", 32'(bus_req_o), 32'd0);
    checkOutput("midrst_stall", 32'(stallreq_o), 32'd0);
    checkOutput("midrst_err", 32'(err_o), 32'd0);
    checkOutput("midrst_wreg", 32'(wreg_o), 32'd0);
    aluop = OP_NOP; mem_addr = '0; wd_in = '0; wreg_in = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #2;

    // Non-memory op passes straight through
    expectRsp(1'b1, 32'h0000_0005, 1'b1, 1'b0, 5'd14, 0, 0);
    applyStimulus(OP_OR, 32'h0, 32'h0, 32'h0000_0005, 5'd14, 1'b1, 0, 32'h0);

    repeat (5) @(negedge clk);
    checkOutput("bus_q_left", 32'(bus_q.size()), 32'd0);
    checkOutput("rsp_q_left", 32'(rsp_q.size()), 32'd0);
    checkOutput("to_q_left", 32'(to_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory-access stage for the five-stage MIPS pipeline. It takes the load/store opcode, effective address and store data produced by the execute stage, runs a request/acknowledge transaction on the data bus, and returns the aligned and extended load result toward write-back. It holds the pipeline through `stallreq_o` until the bus cycle completes. A programmable timeout aborts a hung transaction.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum BUSY cycles without `bus_ack_i` before the transaction aborts. Legal range 1..255.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high (`RstEnable`).
- `aluop_i` in `AluOpBus` [7:0]: opcode from execute.
- `mem_addr_i` in 32: effective address.
- `reg2_i` in 32: store data.
- `wd_i` in 5: destination register.
- `wreg_i` in 1: destination write enable.
- `wdata_i` in 32: non-memory result, passed through.
- `wd_o` out 5: destination register.
- `wreg_o` out 1: write enable toward write-back.
- `wdata_o` out 32: write-back data.
- `stallreq_o` out 1: pipeline stall request.
- `bus_req_o` out 1: bus request.
- `bus_we_o` out 1: 1 = write.
- `bus_addr_o` out 32: word address, `{addr[31:2],2'b00}`.
- `bus_sel_o` out 4: byte enables; bit 3 = bits [31:24].
- `bus_wdata_o` out 32: write data.
- `bus_ack_i` in 1: completion, valid for one cycle.
- `bus_rdata_i` in 32: read data, valid with `bus_ack_i`.
- `err_o` out 1: one-cycle pulse on misalignment or timeout.

## Operation
- Memory opcodes: LB, LBU, LH, LHU, LW, SB, SH, SW. Any other opcode passes through with zero latency: `wd_o`/`wreg_o`/`wdata_o` = inputs, and `stallreq_o` = 0.
- Byte order is big-endian. `addr[1:0]` = 00 selects byte lane [31:24].
  - Byte access: `sel` = 1000 >> `addr[1:0]`.
  - Half access: `sel` = 1100 for `addr[1]` = 0, 0011 for `addr[1]` = 1.
  - Word access: `sel` = 1111.
- Store data is replicated across lanes: SB → `{4{b}}`, SH → `{2{h}}`.
- Loads: LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment: halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0.
  - No bus cycle is issued.
  - `wreg_o` = 0 and `err_o` pulses in the same cycle.
  - `stallreq_o` = 0.
- State machine has three states: IDLE, BUSY, DONE.
  - IDLE, aligned memory op present: `stallreq_o` = 1 (combinational). Latch addr, sel, we, wdata and op into registers. Next state BUSY.
  - BUSY: `bus_req_o` = 1, with all bus outputs driven from the registers and held stable; `stallreq_o` = 1; the wait counter increments.
    - On `bus_ack_i`: capture `bus_rdata_i`, next state DONE.
    - When the counter reaches `TIMEOUT` without ack: next state DONE with the abort flag set.
  - DONE: `stallreq_o` = 0 and `bus_req_o` = 0. For a load, `wreg_o` = `wreg_i` and `wdata_o` = extended captured data. For a store, `wreg_o` = 0. After an abort, `wreg_o` = 0 and `err_o` = 1. Next state is always IDLE; no new request is accepted in DONE.
- `bus_ack_i` is ignored in IDLE and DONE.
- An ack arriving in the same cycle the counter reaches `TIMEOUT` counts as success.

## Timing
- Reset values: state IDLE, counter 0, abort flag 0. All outputs are 0: `bus_req_o`, `bus_we_o`, `bus_addr_o`, `bus_sel_o`, `bus_wdata_o`, `stallreq_o`, `err_o`, `wreg_o`, `wdata_o`, `wd_o`.
- Minimum memory latency, with ack in the first BUSY cycle: 2 stall cycles; the result is presented in cycle 3.
- Each ack wait cycle adds one stall cycle.
- Timeout path: exactly `TIMEOUT` BUSY cycles, then DONE.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and `bus_req_o` drops asynchronously. No completion or error is reported for the interrupted op.

## Structure
- Opcode constants `EXE_LB_OP`…`EXE_SW_OP` and the `AluOpBus`/`RegBus` widths live in `defines.v`.
- Add `MemStateBus` and the IDLE/BUSY/DONE encodings there as well.
- One sub-module: `mem_align`, purely combinational. It contains the byte-enable generation, store replication and load extraction/extension, so it can be unit-tested on its own.
- The FSM and the counter stay in `mem_bus_ctrl`.

## Test plan
- **SW, aligned, immediate ack.** SW, addr 0x0000_0104, data 0xDEAD_BEEF, ack in the first BUSY cycle. Expect `bus_addr_o` 0x104, `sel` 1111, `we` 1, `wdata` 0xDEADBEEF; `stallreq_o` high 2 cycles; `wreg_o` 0 in DONE.
- **LB, sign extension.** LB, addr 0x…0102, `bus_rdata_i` 0x1122_8344. Expect `sel` 0010; `wdata_o` 0xFFFF_FF83 with `wreg_o` = 1 in DONE.
- **LHU, low half.** LHU, addr 0x…0106, rdata 0x0000_F00D. Expect `sel` 0011; `wdata_o` 0x0000_F00D.
- **Ack wait states.** LW with ack delayed 5 cycles. Expect `stallreq_o` high 6 cycles; bus outputs stable throughout; data correct.
- **Misalignment and timeout.**
  - SH to 0x…0101: no `bus_req_o`; `err_o` 1 for one cycle.
  - LW with `TIMEOUT`=4 and no ack: `bus_req_o` high exactly 4 cycles; `err_o` pulses in DONE; `wreg_o` 0.
- **Reset mid-transaction and passthrough.**
  - Assert `rst` during BUSY: `bus_req_o` and `stallreq_o` fall immediately; state IDLE.
  - A following OR op passes `wdata_i` 0x5 to `wdata_o` with no stall.
